dw_denorm_seq: RTL
==================

Name: dw_denorm_seq

Overview:
- Sequential right-shift denormalizer/aligner; the inverse of the leading-zero normalizer.
- Takes a mantissa, an exponent and a right-shift distance. Shifts the mantissa right by at most shift_step bits per cycle, collecting a sticky bit.
- Returns the aligned mantissa with an increased exponent and an overflow flag.
- Sits in front of FP adders/accumulators to align the smaller operand. Valid/ready on both sides.

Parameters:
- a_width, 8, mantissa width (>=2)
- exp_width, 4, width of exponent and shift distance (>=2)
- shift_step, 2, maximum bit positions shifted per cycle (1..a_width)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset; asynchronous assertion, active-low
- in_valid  input  1  request valid
- in_ready  output  1  block can accept a request; equals (state==IDLE)
- a  input  a_width  mantissa to denormalize
- exp_in  input  exp_width  exponent of a
- sh  input  exp_width  right-shift distance, unsigned
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- b  output  a_width  a >> sh
- sticky  output  1  OR of all bits shifted out of a
- exp_out  output  exp_width  (exp_in + sh) mod 2^exp_width
- ovfl  output  1  carry out of exp_in + sh
- busy  output  1  state != IDLE

Behaviour:
- Reset values (asynchronous, active-low):
  - state=IDLE, so in_ready=1 and busy=0.
  - out_valid=0; b, sticky, exp_out and ovfl are all 0.
  - Internal remaining-count cleared.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - An accept occurs when in_valid && in_ready.
  - On accept, register a, sticky=0, exp_out=exp_in+sh (low exp_width bits) and ovfl=carry.
  - Set rem = min(sh, a_width). sh >= a_width is clamped; the result is then 0 and sticky = |a.
  - Next state is DONE if rem==0, else SHIFT.
- SHIFT (once per cycle):
  - k = min(rem, shift_step).
  - b <= b >> k; sticky <= sticky | OR(low k bits of b); rem <= rem - k.
  - Next state is DONE when rem==k, else stay in SHIFT.
- DONE:
  - out_valid=1; b, sticky, exp_out and ovfl are held stable.
  - On out_valid && out_ready, go to IDLE and clear out_valid.
  - A new request is accepted no earlier than the cycle after that handshake (no bypass).
- Latency: out_valid is first high after N = 1 + ceil(rem0/shift_step) rising edges, counting the accept edge. Throughput is one transaction per N+1 cycles when out_ready is held high.
- Inputs a, exp_in and sh are ignored outside the accept cycle.
- in_valid while busy is not accepted and is not lost: the upstream block holds it.
- exp_out and ovfl use the unclamped sh; ovfl is only a carry, with no saturation.
- Reset asserted mid-SHIFT or mid-DONE: the transaction is dropped immediately and all outputs take their reset values. There is no partial result.
- The rem counter needs enough width to hold a_width; size it as max(exp_width, clog2(a_width+1)).

Decomposition:
- Shared package dw_denorm_pkg contains:
  - state enum {IDLE, SHIFT, DONE};
  - a clog2 helper;
  - a min helper for the step size.
- One natural combinational sub-module, dw_denorm_step: inputs b and k, outputs b>>k and the OR of the shifted-out bits. It is parameterized by a_width and shift_step, and instantiated once in the datapath.

Test Plan:
- Nominal shift, a_width=8, step=2: a=8'b1011_0100, exp_in=5, sh=3, out_ready=1 -> b=8'b0001_0110, sticky=1, exp_out=8, ovfl=0, out_valid after 3 edges from accept.
- Zero shift: a=8'hA5, exp_in=4'd9, sh=0 -> b=8'hA5, sticky=0, exp_out=9, out_valid after 1 edge.
- Over-range shift with exponent wrap: a=8'h01, exp_in=6, sh=12 -> b=8'h00, sticky=1, exp_out=4'd2, ovfl=1, out_valid after 5 edges.
- Sticky boundary:
  - a=8'b0000_0100, sh=2 -> b=8'h01, sticky=0.
  - Same a, sh=3 -> b=8'h00, sticky=1.
- Backpressure:
  - Setup: nominal case with out_ready=0 for 5 cycles in DONE, and in_valid held high with a second request.
  - Required: outputs stable throughout and in_ready=0.
  - Second request accepted on the edge after the out handshake.
- Reset mid-operation: sh=7, deassert rst_n during the 2nd SHIFT cycle -> out_valid, b and sticky go to 0 immediately; after release in_ready=1 and the next request completes correctly.

Source files
------------

// File: rtl/dw_denorm_pkg.sv
// Shared types and elaboration helpers for the sequential denormalizer.
package dw_denorm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Number of bits needed to encode values 0..v-1.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Smaller of two non-negative integers (shift step and clamp sizing).
    function automatic int min_int(input int x, input int y);
        return (x < y) ? x : y;
    endfunction

endpackage

// File: rtl/dw_denorm_step.sv
// One shift step: b >> k plus the OR of the bits that fall off the bottom.
module dw_denorm_step
    import dw_denorm_pkg::*;
#(
    parameter int a_width    = 8,
    parameter int shift_step = 2
) (
    input  logic [a_width-1:0]                 b_i,
    input  logic [clog2(shift_step+1)-1:0]     k_i,
    output logic [a_width-1:0]                 b_o,
    output logic                               or_o
);

    // k never exceeds shift_step, so only the low shift_step bits can be lost.
    always_comb begin
        b_o  = b_i >> k_i;
        or_o = 1'b0;
        for (int i = 0; i < shift_step; i++) begin
            if (i < int'(k_i)) or_o = or_o | b_i[i];
        end
    end

endmodule

// File: rtl/dw_denorm_seq.sv
// Sequential right-shift denormalizer: aligns a mantissa by sh bits,
// at most shift_step bits per cycle, accumulating a sticky bit.
module dw_denorm_seq
    import dw_denorm_pkg::*;
#(
    parameter int a_width    = 8,
    parameter int exp_width  = 4,
    parameter int shift_step = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [a_width-1:0]    a,
    input  logic [exp_width-1:0]  exp_in,
    input  logic [exp_width-1:0]  sh,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [a_width-1:0]    b,
    output logic                  sticky,
    output logic [exp_width-1:0]  exp_out,
    output logic                  ovfl,
    output logic                  busy
);

    // rem must hold both any sh value and the clamp value a_width.
    localparam int RW = (exp_width > clog2(a_width + 1)) ? exp_width : clog2(a_width + 1);
    localparam int KW = clog2(shift_step + 1);

    state_t                 state_q, state_d;
    logic [a_width-1:0]     b_q, b_d;
    logic                   sticky_q, sticky_d;
    logic [exp_width-1:0]   exp_q, exp_d;
    logic                   ovfl_q, ovfl_d;
    logic [RW-1:0]          rem_q, rem_d;

    logic [RW-1:0]          rem0;
    logic [RW-1:0]          k_rw;
    logic [KW-1:0]          k_w;
    logic [exp_width:0]     exp_sum;
    logic [a_width-1:0]     b_sh;
    logic                   sh_or;

    // Per-cycle step size, clamped shift distance and widened exponent sum.
    always_comb begin
        k_rw    = RW'(min_int(int'(rem_q), shift_step));
        k_w     = k_rw[KW-1:0];
        rem0    = RW'(min_int(int'(sh), a_width));
        exp_sum = {1'b0, exp_in} + {1'b0, sh};
    end

    dw_denorm_step #(
        .a_width    (a_width),
        .shift_step (shift_step)
    ) u_step (
        .b_i  (b_q),
        .k_i  (k_w),
        .b_o  (b_sh),
        .or_o (sh_or)
    );

    // State and datapath registers; reset drops any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            b_q      <= '0;
            sticky_q <= 1'b0;
            exp_q    <= '0;
            ovfl_q   <= 1'b0;
            rem_q    <= '0;
        end else begin
            state_q  <= state_d;
            b_q      <= b_d;
            sticky_q <= sticky_d;
            exp_q    <= exp_d;
            ovfl_q   <= ovfl_d;
            rem_q    <= rem_d;
        end
    end

    // Next-state logic: accept in IDLE, shift until rem runs out, hold in DONE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (in_valid) state_d = (rem0 == '0) ? DONE : SHIFT;
            SHIFT:   if (rem_q == k_rw) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values: load on accept, shift in SHIFT, otherwise hold.
    always_comb begin
        b_d      = b_q;
        sticky_d = sticky_q;
        exp_d    = exp_q;
        ovfl_d   = ovfl_q;
        rem_d    = rem_q;
        if (state_q == IDLE && in_valid) begin
            b_d             = a;
            sticky_d        = 1'b0;
            {ovfl_d, exp_d} = exp_sum;
            rem_d           = rem0;
        end else if (state_q == SHIFT) begin
            b_d      = b_sh;
            sticky_d = sticky_q | sh_or;
            rem_d    = rem_q - k_rw;
        end
    end

    // Handshake and status outputs are pure decodes of the state.
    always_comb begin
        in_ready  = (state_q == IDLE);
        busy      = (state_q != IDLE);
        out_valid = (state_q == DONE);
    end

    assign b       = b_q;
    assign sticky  = sticky_q;
    assign exp_out = exp_q;
    assign ovfl    = ovfl_q;

endmodule
